// File: rtl/mul16_engine_pkg.sv
// Shared types and constants for the 16-pair signed multiply engine.
package mul_engine_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        MUL   = 3'd2,
        FIX   = 3'd3,
        STORE = 3'd4,
        DONE  = 3'd5
    } state_e;

    localparam int MUL_CYCLES     = 16;
    localparam int BYTES_PER_OPND = 2;
    localparam int BYTES_PER_PROD = 4;
    localparam int LOAD_CYCLES    = 2 * BYTES_PER_OPND + 1;

    // Big-endian byte k of a 32-bit product (k=0 is the most significant byte).
    function automatic logic [7:0] prod_byte(input logic [31:0] p, input logic [1:0] k);
        logic [7:0] b;
        case (k)
            2'd0:    b = p[31:24];
            2'd1:    b = p[23:16];
            2'd2:    b = p[15:8];
            2'd3:    b = p[7:0];
            default: b = 8'd0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/mul16x16_seq.sv
// Sequential signed 16x16 multiplier: sign-magnitude, radix-2 shift-add, one bit per cycle.
module mul16x16_seq
    import mul_engine_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        go,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic [31:0] prod
);

    logic [31:0] mcand_r;
    logic [15:0] mplier_r;
    logic [31:0] acc_r;
    logic        neg_r;
    logic [3:0]  bit_r;
    logic        busy_r;
    logic [31:0] prod_r;
    logic [31:0] sum_s;
    logic [31:0] fixed_s;

    // |-32768| maps to 16'h8000, which is still representable as unsigned.
    function automatic logic [15:0] mag16(input logic [15:0] v);
        return v[15] ? (16'd0 - v) : v;
    endfunction

    // Partial-product accumulate and final sign fix; a zero magnitude negates to zero.
    always_comb begin
        sum_s   = mplier_r[0] ? (acc_r + mcand_r) : acc_r;
        fixed_s = neg_r ? (32'd0 - sum_s) : sum_s;
    end

    // Operand capture on go, then sixteen shift-add steps; the last step latches the signed result.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_r  <= 32'd0;
            mplier_r <= 16'd0;
            acc_r    <= 32'd0;
            neg_r    <= 1'b0;
            bit_r    <= 4'd0;
            busy_r   <= 1'b0;
            prod_r   <= 32'd0;
        end else if (go) begin
            mcand_r  <= {16'd0, mag16(a)};
            mplier_r <= mag16(b);
            acc_r    <= 32'd0;
            neg_r    <= a[15] ^ b[15];
            bit_r    <= 4'd0;
            busy_r   <= 1'b1;
        end else if (busy_r) begin
            acc_r    <= sum_s;
            mcand_r  <= {mcand_r[30:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[15:1]};
            bit_r    <= bit_r + 4'd1;
            if (bit_r == 4'(MUL_CYCLES - 1)) begin
                busy_r <= 1'b0;
                prod_r <= fixed_s;
            end
        end
    end

    assign busy = busy_r;
    assign prod = prod_r;

endmodule

// File: rtl/mul16_engine.sv
// Bus-master engine: on a start fall, multiplies 16 operand pairs from memory and writes products back.
module mul16_engine
    import mul_engine_pkg::*;
#(
    parameter int N_PAIRS  = 16,
    parameter int OUT_BASE = 64,
    parameter int ADDR_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rd_data,
    output logic              mem_wr_en,
    output logic [7:0]        mem_wr_data
);

    localparam int PW = $clog2(N_PAIRS);

    state_e          state_r, state_n;
    logic            start_q_r;
    logic [4:0]      cnt_r;
    logic [PW-1:0]   pair_r;
    logic [7:0]      a_hi_r, a_lo_r, b_hi_r;
    logic            launch_s, go_s, last_s, busy_s;
    logic [31:0]     prod_s;

    mul16x16_seq u_mul (
        .clk   (clk),
        .reset (reset),
        .go    (go_s),
        .a     ({a_hi_r, a_lo_r}),
        .b     ({b_hi_r, mem_rd_data}),
        .busy  (busy_s),
        .prod  (prod_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state logic; go fires in the last LOAD cycle while B's low byte is on the read bus.
    always_comb begin
        state_n  = state_r;
        go_s     = 1'b0;
        launch_s = (state_r == IDLE) && start_q_r && !start;
        last_s   = (pair_r == PW'(N_PAIRS - 1));
        case (state_r)
            IDLE:    state_n = launch_s ? LOAD : IDLE;
            LOAD: begin
                if (cnt_r == 5'(LOAD_CYCLES - 1)) begin
                    state_n = MUL;
                    go_s    = 1'b1;
                end else begin
                    state_n = LOAD;
                end
            end
            MUL:     state_n = (cnt_r == 5'(MUL_CYCLES - 1)) ? FIX : MUL;
            FIX:     state_n = busy_s ? FIX : STORE;
            STORE: begin
                if (cnt_r == 5'(BYTES_PER_PROD - 1)) begin
                    state_n = last_s ? DONE : LOAD;
                end else begin
                    state_n = STORE;
                end
            end
            DONE:    state_n = start ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end

    // Memory sequencing, operand capture and the done handshake; all outputs are registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            start_q_r   <= 1'b0;
            cnt_r       <= 5'd0;
            pair_r      <= '0;
            a_hi_r      <= 8'd0;
            a_lo_r      <= 8'd0;
            b_hi_r      <= 8'd0;
            done        <= 1'b0;
            mem_addr    <= '0;
            mem_wr_en   <= 1'b0;
            mem_wr_data <= 8'd0;
        end else begin
            start_q_r <= start;
            cnt_r     <= (state_n != state_r) ? 5'd0 : (cnt_r + 5'd1);
            // done rises one edge after entering DONE and drops on the edge that sees start high.
            done      <= (state_r == DONE) && !start;
            case (state_r)
                IDLE: begin
                    if (launch_s) begin
                        pair_r   <= '0;
                        mem_addr <= '0;
                    end
                end
                LOAD: begin
                    if (cnt_r < 5'd3) begin
                        mem_addr <= mem_addr + ADDR_W'(1);
                    end
                    case (cnt_r)
                        5'd1:    a_hi_r <= mem_rd_data;
                        5'd2:    a_lo_r <= mem_rd_data;
                        5'd3:    b_hi_r <= mem_rd_data;
                        default: ;
                    endcase
                end
                FIX: begin
                    if (!busy_s) begin
                        mem_wr_en   <= 1'b1;
                        mem_addr    <= ADDR_W'(OUT_BASE) + ADDR_W'({pair_r, 2'b00});
                        mem_wr_data <= prod_byte(prod_s, 2'd0);
                    end
                end
                STORE: begin
                    if (cnt_r == 5'(BYTES_PER_PROD - 1)) begin
                        mem_wr_en <= 1'b0;
                        if (!last_s) begin
                            pair_r   <= pair_r + PW'(1);
                            mem_addr <= ADDR_W'({pair_r + PW'(1), 2'b00});
                        end
                    end else begin
                        mem_addr    <= mem_addr + ADDR_W'(1);
                        mem_wr_data <= prod_byte(prod_s, cnt_r[1:0] + 2'd1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul16_engine.sv
// Directed/randomized bench for mul16_engine with a byte memory model and an arithmetic golden model.
module tb_mul16_engine;

    logic       clk;
    logic       reset;
    logic       start;
    logic       done;
    logic [7:0] mem_addr;
    logic [7:0] mem_rd_data;
    logic       mem_wr_en;
    logic [7:0] mem_wr_data;

    logic [7:0] opnd [64];
    logic [7:0] pmem [64];
    logic       clr_prod;
    int         wr_count;
    int         stray_wr;
    int         checks;
    int         errors;

    mul16_engine #(.N_PAIRS(16), .OUT_BASE(64), .ADDR_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .done        (done),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_data (mem_wr_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Registered-read byte memory: operands below 64, product area 64..127.
    always @(posedge clk) begin
        if (clr_prod) begin
            for (int i = 0; i < 64; i++) pmem[i] <= 8'hAA;
        end else if (mem_wr_en) begin
            wr_count <= wr_count + 1;
            if (mem_addr >= 8'd64 && mem_addr < 8'd128) pmem[mem_addr - 8'd64] <= mem_wr_data;
            else stray_wr <= stray_wr + 1;
        end
        mem_rd_data <= (mem_addr < 8'd64) ? opnd[mem_addr[5:0]] : 8'h00;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_pair(input int j, input logic [15:0] a, input logic [15:0] b);
        opnd[4*j]   = a[15:8];
        opnd[4*j+1] = a[7:0];
        opnd[4*j+2] = b[15:8];
        opnd[4*j+3] = b[7:0];
    endtask

    function automatic logic [31:0] golden(input int j);
        logic signed [15:0] a;
        logic signed [15:0] b;
        int av, bv;
        a  = {opnd[4*j], opnd[4*j+1]};
        b  = {opnd[4*j+2], opnd[4*j+3]};
        av = a;
        bv = b;
        return 32'(av * bv);
    endfunction

    task automatic clear_products();
        @(negedge clk) clr_prod = 1'b1;
        @(negedge clk) clr_prod = 1'b0;
    endtask

    task automatic check_products(input string tag, input int first, input int last_j, input logic untouched);
        for (int j = first; j <= last_j; j++) begin
            chk(tag, {pmem[4*j], pmem[4*j+1], pmem[4*j+2], pmem[4*j+3]},
                untouched ? 32'hAAAA_AAAA : golden(j));
        end
    endtask

    // Launch with a start fall, measure edges until done, optionally toggle start mid-run.
    task automatic run(input string tag, input int glitch_at);
        int base, lat;
        lat  = -1;
        base = wr_count;
        @(negedge clk) start = 1'b0;
        @(posedge clk);
        for (int n = 1; n <= 600; n++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = n;
                break;
            end
            if (n == glitch_at) start = 1'b1;
            if (n == glitch_at + 1) start = 1'b0;
        end
        chk({tag, "_latency"}, 32'(lat), 32'd417);
        chk({tag, "_writes_before_done"}, 32'(wr_count - base), 32'd64);
        base = wr_count;
        repeat (5) @(posedge clk);
        #1;
        chk({tag, "_done_holds"}, {31'd0, done}, 32'd1);
        chk({tag, "_no_writes_in_done"}, 32'(wr_count - base), 32'd0);
        check_products({tag, "_prod"}, 0, 15, 1'b0);
    endtask

    task automatic release_start(input string tag);
        @(negedge clk) start = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_done_clears"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int base;
        checks   = 0;
        errors   = 0;
        wr_count = 0;
        stray_wr = 0;
        clr_prod = 1'b0;
        reset    = 1'b1;
        start    = 1'b1;
        for (int i = 0; i < 64; i++) opnd[i] = 8'h00;
        repeat (3) @(posedge clk);
        clear_products();
        @(negedge clk) reset = 1'b0;
        #1;
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_wr_en", {31'd0, mem_wr_en}, 32'd0);
        chk("reset_addr", {24'd0, mem_addr}, 32'd0);
        chk("reset_wr_data", {24'd0, mem_wr_data}, 32'd0);
        repeat (2) @(posedge clk);

        // 1: 3 x -5, all other pairs zero
        set_pair(0, 16'h0003, 16'hFFFB);
        run("t1", 0);
        chk("t1_p0_literal", {pmem[0], pmem[1], pmem[2], pmem[3]}, 32'hFFFF_FFF1);
        release_start("t1");

        // 2: extreme operands
        set_pair(0, 16'h8000, 16'h8000);
        set_pair(1, 16'h7FFF, 16'h8000);
        for (int j = 2; j < 16; j++) set_pair(j, 16'($urandom), 16'($urandom));
        run("t2", 0);
        chk("t2_p0_literal", {pmem[0], pmem[1], pmem[2], pmem[3]}, 32'h4000_0000);
        chk("t2_p1_literal", {pmem[4], pmem[5], pmem[6], pmem[7]}, 32'hC000_8000);
        release_start("t2");

        // 3: random pairs with 0 and +/-1 mixed in
        for (int j = 0; j < 16; j++) set_pair(j, 16'($urandom), 16'($urandom));
        set_pair(0, 16'h0000, 16'($urandom));
        set_pair(1, 16'h0001, 16'($urandom));
        set_pair(2, 16'hFFFF, 16'($urandom));
        set_pair(3, 16'($urandom), 16'hFFFF);
        set_pair(4, 16'hFFFF, 16'h0000);
        run("t3", 0);
        release_start("t3");

        // 5: start toggles mid-run are ignored
        for (int j = 0; j < 16; j++) set_pair(j, 16'($urandom), 16'($urandom));
        run("t5", 100);
        release_start("t5");

        // 4: reset during MUL of pair 5, then a fresh run
        for (int j = 0; j < 16; j++) set_pair(j, 16'($urandom), 16'($urandom));
        clear_products();
        @(negedge clk) start = 1'b0;
        @(posedge clk);
        repeat (140) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        chk("t4_rst_done", {31'd0, done}, 32'd0);
        chk("t4_rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
        chk("t4_rst_addr", {24'd0, mem_addr}, 32'd0);
        chk("t4_rst_wr_data", {24'd0, mem_wr_data}, 32'd0);
        @(negedge clk) reset = 1'b0;
        base = wr_count;
        repeat (500) @(posedge clk);
        #1;
        chk("t4_no_writes_after_reset", 32'(wr_count - base), 32'd0);
        chk("t4_done_low_after_reset", {31'd0, done}, 32'd0);
        check_products("t4_kept", 0, 4, 1'b0);
        check_products("t4_untouched", 5, 15, 1'b1);
        release_start("t4");
        run("t4_rerun", 0);

        // 6: second data set on a back-to-back run
        release_start("t6");
        for (int j = 0; j < 16; j++) set_pair(j, 16'($urandom), 16'($urandom));
        run("t6", 0);

        chk("stray_writes", 32'(stray_wr), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
